// File: rtl/usbf_dma_arb.sv
// rtl/usbf_dma_arb.sv - round-robin arbiter of endpoint DMA requests onto one DMA handshake channel
module usbf_dma_arb #(
  parameter int N_EP      = 4,
  parameter int MAX_BURST = 8,
  parameter int BW        = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_EP-1:0] ep_dma_req,
  output logic [N_EP-1:0] ep_dma_ack,
  output logic            dma_req,
  input  logic            dma_ack,
  output logic [3:0]      dma_sel,
  output logic            busy,
  output logic            stray_ack,
  input  logic            stray_clr
);

  localparam int IW = (N_EP > 1) ? $clog2(N_EP) : 1;
  localparam logic [IW-1:0] LAST_INIT  = IW'(N_EP - 1);
  localparam logic [BW-1:0] BURST_LAST = (MAX_BURST == 0) ? '0 : BW'(MAX_BURST - 1);
  localparam logic [BW-1:0] CNT_MAX    = {BW{1'b1}};

  typedef enum logic [1:0] {IDLE, ARB, GRANT, RELEASE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   grant_idx;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   pick;
  logic            found;
  logic [BW-1:0]   burst_cnt;
  logic            in_grant;
  logic            req_g;
  logic            burst_end;
  int              j;

  assign in_grant  = (state == GRANT);
  assign req_g     = ep_dma_req[grant_idx];
  // With MAX_BURST of zero the limit never triggers and the grant lasts as long as the request.
  assign burst_end = (MAX_BURST != 0) && dma_ack && (burst_cnt == BURST_LAST);

  assign dma_req    = in_grant & req_g;
  assign ep_dma_ack = (in_grant && dma_ack) ? (N_EP'(1) << grant_idx) : '0;
  assign busy       = (state != IDLE);

  // Round-robin search starting just after the previous winner, wrapping modulo N_EP.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    j     = 0;
    for (int k = 1; k <= N_EP; k++) begin
      j = (int'(last_grant) + k) % N_EP;
      if (!found && ep_dma_req[j]) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; RELEASE always inserts one dead cycle before returning to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|ep_dma_req) state_nxt = ARB;
      ARB:     state_nxt = found ? GRANT : IDLE;
      GRANT:   if (burst_end || (!req_g && !dma_ack)) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant index, channel select, burst counter and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_idx  <= '0;
      dma_sel    <= '0;
      last_grant <= LAST_INIT;
      burst_cnt  <= '0;
    end else begin
      case (state)
        ARB: begin
          if (found) begin
            grant_idx <= pick;
            dma_sel   <= 4'(pick);
          end
          burst_cnt <= '0;
        end
        GRANT: begin
          if (dma_ack && (burst_cnt != CNT_MAX)) burst_cnt <= burst_cnt + BW'(1);
        end
        RELEASE: last_grant <= grant_idx;
        default: ;
      endcase
    end
  end

  // Sticky flag for acks arriving when no endpoint holds the grant; a new stray ack beats a clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   stray_ack <= 1'b0;
    else if (dma_ack && !in_grant) stray_ack <= 1'b1;
    else if (stray_clr)         stray_ack <= 1'b0;
  end

endmodule

// File: tb/tb_usbf_dma_arb.sv
// tb/tb_usbf_dma_arb.sv - table-driven scoreboard bench for usbf_dma_arb
module tb_usbf_dma_arb;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default burst limit of 8
  logic       rst_a = 1'b0, ack_a = 1'b0, clr_a = 1'b0;
  logic [3:0] req_a = 4'b0;
  logic [3:0] epack_a, sel_a;
  logic       dreq_a, busy_a, stray_a;

  // DUT B: unlimited burst
  logic       rst_b = 1'b0, ack_b = 1'b0, clr_b = 1'b0;
  logic [3:0] req_b = 4'b0;
  logic [3:0] epack_b, sel_b;
  logic       dreq_b, busy_b, stray_b;

  usbf_dma_arb #(.N_EP(4), .MAX_BURST(8), .BW(8)) u_a (
    .clk(clk), .rst(rst_a), .ep_dma_req(req_a), .ep_dma_ack(epack_a),
    .dma_req(dreq_a), .dma_ack(ack_a), .dma_sel(sel_a), .busy(busy_a),
    .stray_ack(stray_a), .stray_clr(clr_a));

  usbf_dma_arb #(.N_EP(4), .MAX_BURST(0), .BW(8)) u_b (
    .clk(clk), .rst(rst_b), .ep_dma_req(req_b), .ep_dma_ack(epack_b),
    .dma_req(dreq_b), .dma_ack(ack_b), .dma_sel(sel_b), .busy(busy_b),
    .stray_ack(stray_b), .stray_clr(clr_b));

  typedef struct {
    int         idx;
    bit         b;
    logic       rst;
    logic [3:0] req;
    logic       ack;
    logic       clr;
    bit         full;
    logic       e_req;
    logic [3:0] e_ack;
    logic [3:0] e_sel;
    logic       e_busy;
    logic       e_stray;
  } vec_t;

  vec_t tbl[$];
  vec_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input bit b, input logic r, input logic [3:0] q, input logic a,
                     input logic c, input bit f, input logic er, input logic [3:0] ea,
                     input logic [3:0] es, input logic eb, input logic est);
    vec_t v;
    v.idx = tbl.size(); v.b = b; v.rst = r; v.req = q; v.ack = a; v.clr = c;
    v.full = f; v.e_req = er; v.e_ack = ea; v.e_sel = es; v.e_busy = eb; v.e_stray = est;
    tbl.push_back(v);
  endtask

  // Checker: pops one expectation per cycle and samples the addressed DUT mid-cycle.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      vec_t e;
      logic       g_req, g_busy, g_stray;
      logic [3:0] g_ack, g_sel;
      bit         ok;
      e = sbq.pop_front();
      g_req   = e.b ? dreq_b  : dreq_a;
      g_ack   = e.b ? epack_b : epack_a;
      g_sel   = e.b ? sel_b   : sel_a;
      g_busy  = e.b ? busy_b  : busy_a;
      g_stray = e.b ? stray_b : stray_a;
      ok = (g_req == e.e_req) && (g_ack == e.e_ack);
      if (e.full)
        ok = ok && (g_sel == e.e_sel) && (g_busy == e.e_busy) && (g_stray == e.e_stray);
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL vec%0d dut_%s: got dma_req=%b ep_dma_ack=%b dma_sel=%0d busy=%b stray_ack=%b, expected %b %b %0d %b %b (sel/busy/stray checked=%0d)",
                 e.idx, e.b ? "b" : "a", g_req, g_ack, g_sel, g_busy, g_stray,
                 e.e_req, e.e_ack, e.e_sel, e.e_busy, e.e_stray, e.full);
      end
    end
  end

  initial begin
    logic [3:0] oh;
    int         order[4] = '{0, 1, 3, 0};

    // Reset, then single requester ep2 with 5 acks and a drop
    add(0, 0, 4'b0000, 0, 0, 1, 0, 4'b0000, 0, 0, 0);
    add(0, 1, 4'b0100, 0, 0, 1, 0, 4'b0000, 0, 0, 0);
    add(0, 1, 4'b0100, 0, 0, 1, 0, 4'b0000, 0, 1, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 4'b0100, 1, 0, 1, 1, 4'b0100, 2, 1, 0);
    add(0, 1, 4'b0000, 0, 0, 1, 0, 4'b0000, 2, 1, 0);
    add(0, 1, 4'b0000, 0, 0, 1, 0, 4'b0000, 2, 1, 0);
    add(0, 1, 4'b0000, 0, 0, 1, 0, 4'b0000, 2, 0, 0);
    // ep0 drops its request in the same cycle as the ack
    add(0, 1, 4'b0001, 0, 0, 1, 0, 4'b0000, 2, 0, 0);
    add(0, 1, 4'b0001, 0, 0, 1, 0, 4'b0000, 2, 1, 0);
    add(0, 1, 4'b0001, 0, 0, 1, 1, 4'b0000, 0, 1, 0);
    add(0, 1, 4'b0000, 1, 0, 1, 0, 4'b0001, 0, 1, 0);
    add(0, 1, 4'b0000, 0, 0, 1, 0, 4'b0000, 0, 1, 0);
    add(0, 1, 4'b0000, 0, 0, 1, 0, 4'b0000, 0, 1, 0);
    add(0, 1, 4'b0000, 0, 0, 1, 0, 4'b0000, 0, 0, 0);
    // Stray acks in IDLE; set beats coincident clear
    add(0, 1, 4'b0000, 1, 0, 1, 0, 4'b0000, 0, 0, 0);
    add(0, 1, 4'b0000, 1, 1, 1, 0, 4'b0000, 0, 0, 1);
    add(0, 1, 4'b0000, 0, 1, 1, 0, 4'b0000, 0, 0, 1);
    add(0, 1, 4'b0000, 0, 0, 1, 0, 4'b0000, 0, 0, 0);
    // Grant ep2, then asynchronous reset mid-grant with ep2 and ep0 requesting
    add(0, 1, 4'b0100, 0, 0, 1, 0, 4'b0000, 0, 0, 0);
    add(0, 1, 4'b0100, 0, 0, 1, 0, 4'b0000, 0, 1, 0);
    add(0, 1, 4'b0100, 0, 0, 1, 1, 4'b0000, 2, 1, 0);
    add(0, 0, 4'b0101, 0, 0, 1, 0, 4'b0000, 0, 0, 0);
    add(0, 1, 4'b0101, 0, 0, 1, 0, 4'b0000, 0, 0, 0);
    add(0, 1, 4'b0101, 0, 0, 1, 0, 4'b0000, 0, 1, 0);
    add(0, 1, 4'b0101, 1, 0, 1, 1, 4'b0001, 0, 1, 0);
    add(0, 1, 4'b0100, 0, 0, 1, 0, 4'b0000, 0, 1, 0);
    add(0, 1, 4'b0100, 0, 0, 1, 0, 4'b0000, 0, 1, 0);
    add(0, 1, 4'b0100, 0, 0, 1, 0, 4'b0000, 0, 0, 0);
    add(0, 1, 4'b0100, 0, 0, 1, 0, 4'b0000, 0, 1, 0);
    add(0, 1, 4'b0100, 0, 0, 1, 1, 4'b0000, 2, 1, 0);
    add(0, 1, 4'b0000, 0, 0, 1, 0, 4'b0000, 2, 1, 0);
    add(0, 1, 4'b0000, 0, 0, 1, 0, 4'b0000, 2, 1, 0);
    add(0, 1, 4'b0000, 0, 0, 1, 0, 4'b0000, 2, 0, 0);
    // Round-robin fairness with burst limit 8 and continuous acks
    add(0, 0, 4'b1011, 1, 0, 0, 0, 4'b0000, 0, 0, 0);
    add(0, 1, 4'b1011, 1, 0, 0, 0, 4'b0000, 0, 0, 0);
    add(0, 1, 4'b1011, 1, 0, 0, 0, 4'b0000, 0, 0, 0);
    for (int g = 0; g < 4; g++) begin
      oh = 4'b0001 << order[g];
      for (int i = 0; i < 8; i++) add(0, 1, 4'b1011, 1, 0, 0, 1, oh, 0, 0, 0);
      for (int i = 0; i < 3; i++) add(0, 1, 4'b1011, 1, 0, 0, 0, 4'b0000, 0, 0, 0);
    end
    // Unlimited burst on DUT B: ep1 holds the grant through 300 acks, then ep3
    add(1, 0, 4'b1010, 0, 0, 1, 0, 4'b0000, 0, 0, 0);
    add(1, 1, 4'b1010, 0, 0, 1, 0, 4'b0000, 0, 0, 0);
    add(1, 1, 4'b1010, 0, 0, 1, 0, 4'b0000, 0, 1, 0);
    for (int i = 0; i < 300; i++) add(1, 1, 4'b1010, 1, 0, 1, 1, 4'b0010, 1, 1, 0);
    add(1, 1, 4'b1000, 0, 0, 1, 0, 4'b0000, 1, 1, 0);
    add(1, 1, 4'b1000, 0, 0, 1, 0, 4'b0000, 1, 1, 0);
    add(1, 1, 4'b1000, 0, 0, 1, 0, 4'b0000, 1, 0, 0);
    add(1, 1, 4'b1000, 0, 0, 1, 0, 4'b0000, 1, 1, 0);
    add(1, 1, 4'b1000, 0, 0, 1, 1, 4'b0000, 3, 1, 0);
    add(1, 1, 4'b0000, 0, 0, 1, 0, 4'b0000, 3, 1, 0);

    // Driver: apply one record per cycle just after the edge and queue its expectation
    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      if (tbl[i].b) begin
        rst_b = tbl[i].rst; req_b = tbl[i].req; ack_b = tbl[i].ack; clr_b = tbl[i].clr;
      end else begin
        rst_a = tbl[i].rst; req_a = tbl[i].req; ack_a = tbl[i].ack; clr_a = tbl[i].clr;
      end
      sbq.push_back(tbl[i]);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
